store_row: RTL and testbench
============================

// Module: store_row
// PURPOSE
//  Write-side counterpart of the row loader. Takes one finished convolution output row
//  (OUT_W = IMAGE_WIDTH-FILTER_SIZE+1 signed accumulator values) and converts each value to an 8-bit pixel.
//  Writes the pixels one per cycle into the output BRAM through port A.
//  Sits between the convolution datapath and the result BRAM; the controller steps rows with store_en/stored.
// PARAMETERS
//  IMAGE_WIDTH   128  input image width; OUT_W = IMAGE_WIDTH-FILTER_SIZE+1
//  IMAGE_HEIGHT  128  input image height; OUT_H = IMAGE_HEIGHT-FILTER_SIZE+1
//  FILTER_SIZE   3    kernel edge length
//  ACC_WIDTH     16   width of each signed accumulator value in row_in_flat
// PORTS
//  clk          in   1                   single clock, rising edge
//  rst          in   1                   asynchronous, active-high reset
//  store_en     in   1                   level request: store one row; held until stored seen
//  row_count    in   16                  output row index (0..OUT_H-1)
//  row_in_flat  in   OUT_W*ACC_WIDTH     signed values; element k at [k*ACC_WIDTH +: ACC_WIDTH]
//  bram_en_a    out  1                   BRAM port A enable
//  bram_we_a    out  1                   BRAM port A write enable
//  bram_addr_a  out  $clog2(OUT_W*OUT_H) write address = row_count*OUT_W + col
//  bram_din_a   out  8                   write data
//  busy         out  1                   high in WRITE state
//  stored       out  1                   row finished; held until store_en low
//  row_err      out  1                   row_count >= OUT_H on last request
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE; col=0; all outputs 0.
//   Reset mid-row aborts the row; pixels already written stay in BRAM.
//  FSM states: IDLE, WRITE, DONE. All outputs are registered.
//  IDLE:
//   - Start condition: store_en=1 sampled at edge N.
//   - On start: snapshot row_in_flat into an internal register; latch base = row_count*OUT_W; col<=0; row_err<=0.
//   - If row_count >= OUT_H: row_err<=1, state<=DONE; no BRAM write occurs.
//   - Otherwise: state<=WRITE.
//  WRITE (one pixel per edge, no stalls):
//   - Each edge: bram_en_a<=1; bram_we_a<=1; bram_addr_a<=base+col; bram_din_a<=conv(snap[col]); busy=1.
//   - When col==OUT_W-1: state<=DONE; otherwise col<=col+1.
//   - Writes issue at edges N+1..N+OUT_W; BRAM captures at edges N+2..N+OUT_W+1.
//  DONE:
//   - First edge: bram_en_a<=0; bram_we_a<=0; busy<=0; stored<=1 (visible after edge N+OUT_W+1).
//   - Holds stored=1 while store_en=1.
//   - First edge with store_en=0: stored<=0, state<=IDLE.
//   - If store_en is already low, stored is high for exactly one cycle.
//  Handshake:
//   - store_en/row_count/row_in_flat changes after the start edge are ignored (snapshot).
//   - store_en dropping during WRITE does not abort the row.
//   - A new row needs store_en low for at least one cycle in DONE/IDLE.
//  Conversion conv(x) (x signed ACC_WIDTH): x<0 -> 0; x>255 -> 255; else x[7:0].
//  Address math: unsigned, width $clog2(OUT_W*OUT_H); the last legal row ends at OUT_W*OUT_H-1, no wrap.
//  bram_en_a and bram_we_a are only ever 1 together; the block never reads.
// CONFIGURATION
//  STORE_ABS_EN defined: conv(x) = min(|x|,255) for edge-magnitude kernels.
//   |most-negative| saturates to 255.
//  STORE_ABS_EN undefined: negative values clamp to 0 as above. No port or timing change either way.
// TESTING (IMAGE_WIDTH=8, IMAGE_HEIGHT=8, FILTER_SIZE=3 -> OUT_W=6, OUT_H=6, addr 6 bits)
//  1 row_count=2, values {0,1,2,3,4,5}, store_en held
//    -> 6 writes at addr 12..17, data 0..5 on consecutive cycles;
//    -> stored=1 at edge N+7 and held; drop store_en -> stored=0 next edge.
//  2 values {-5,300,255,256,-32768,128}
//    -> without STORE_ABS_EN: data {0,255,255,255,0,128};
//    -> with STORE_ABS_EN: data {5,255,255,255,255,128}.
//  3 row_count=6 (out of range)
//    -> no bram_we_a pulse; row_err=1 and stored=1 after edge N+1.
//  4 Change row_in_flat and row_count, and drop store_en, during WRITE
//    -> written data/addresses match the start-edge snapshot; stored still pulses.
//  5 Assert rst at the 3rd write
//    -> all outputs 0 immediately (async); addr 12..13 written, nothing more.
//    -> A new request after reset completes normally.
//  6 Back-to-back rows 0..5, store_en dropped for one cycle between rows
//    -> 36 writes covering addr 0..35 exactly once each; busy high only during writes.

Source files
------------

// File: rtl/store_row_if.sv
// Row-store handshake and BRAM port A write bus.
// Shared by the row controller (master) and store_row (slave).
interface store_row_if #(
    parameter int IMAGE_WIDTH  = 128,
    parameter int IMAGE_HEIGHT = 128,
    parameter int FILTER_SIZE  = 3,
    parameter int ACC_WIDTH    = 16
);
    localparam int OUT_W = IMAGE_WIDTH - FILTER_SIZE + 1;
    localparam int OUT_H = IMAGE_HEIGHT - FILTER_SIZE + 1;
    localparam int AW    = $clog2(OUT_W * OUT_H);

    logic                       store_en;
    logic [15:0]                row_count;
    logic [OUT_W*ACC_WIDTH-1:0] row_in_flat;
    logic                       bram_en_a;
    logic                       bram_we_a;
    logic [AW-1:0]              bram_addr_a;
    logic [7:0]                 bram_din_a;
    logic                       busy;
    logic                       stored;
    logic                       row_err;

    modport master (
        output store_en, row_count, row_in_flat,
        input  bram_en_a, bram_we_a, bram_addr_a, bram_din_a,
        input  busy, stored, row_err
    );

    modport slave (
        input  store_en, row_count, row_in_flat,
        output bram_en_a, bram_we_a, bram_addr_a, bram_din_a,
        output busy, stored, row_err
    );
endinterface

// File: rtl/store_row.sv
// Converts one convolution output row to 8-bit pixels and writes them to BRAM port A.
// Define STORE_ABS_EN to convert with min(|x|,255) instead of clamping negatives to 0.
module store_row #(
    parameter int IMAGE_WIDTH  = 128,
    parameter int IMAGE_HEIGHT = 128,
    parameter int FILTER_SIZE  = 3,
    parameter int ACC_WIDTH    = 16
) (
    input  logic      clk,
    input  logic      rst,
    store_row_if.slave bus_io
);
    localparam int OUT_W = IMAGE_WIDTH - FILTER_SIZE + 1;
    localparam int OUT_H = IMAGE_HEIGHT - FILTER_SIZE + 1;
    localparam int AW    = $clog2(OUT_W * OUT_H);
    localparam int CW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int ROW_W = OUT_W * ACC_WIDTH;

    localparam logic [CW-1:0] COL_LAST = CW'(OUT_W - 1);
    localparam logic [15:0]   ROWS     = 16'(OUT_H);

    localparam logic signed [ACC_WIDTH-1:0] SAT   = ACC_WIDTH'(255);
    localparam logic signed [ACC_WIDTH:0]   SAT_E = (ACC_WIDTH + 1)'(255);

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   col_q, col_d;
    logic [AW-1:0]   base_q, base_d;
    logic [ROW_W-1:0] snap_q, snap_d;
    logic            en_q, en_d;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [7:0]      din_q, din_d;
    logic            busy_q, busy_d;
    logic            stored_q, stored_d;
    logic            err_q, err_d;

    function automatic logic [7:0] conv(input logic signed [ACC_WIDTH-1:0] x);
`ifdef STORE_ABS_EN
        logic signed [ACC_WIDTH:0] xe;
        logic signed [ACC_WIDTH:0] m;
        // One extra bit so the most negative value has a representable magnitude
        xe = {x[ACC_WIDTH-1], x};
        m  = x[ACC_WIDTH-1] ? -xe : xe;
        conv = (m > SAT_E) ? 8'hFF : m[7:0];
`else
        if (x[ACC_WIDTH-1])
            conv = 8'h00;
        else if (x > SAT)
            conv = 8'hFF;
        else
            conv = x[7:0];
`endif
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            col_q    <= '0;
            base_q   <= '0;
            snap_q   <= '0;
            en_q     <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            din_q    <= '0;
            busy_q   <= 1'b0;
            stored_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            base_q   <= base_d;
            snap_q   <= snap_d;
            en_q     <= en_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            busy_q   <= busy_d;
            stored_q <= stored_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        base_d   = base_q;
        snap_d   = snap_q;
        en_d     = en_q;
        we_d     = we_q;
        addr_d   = addr_q;
        din_d    = din_q;
        busy_d   = busy_q;
        stored_d = stored_q;
        err_d    = err_q;

        unique case (state_q)
            IDLE: begin
                en_d     = 1'b0;
                we_d     = 1'b0;
                busy_d   = 1'b0;
                stored_d = 1'b0;
                if (bus_io.store_en) begin
                    snap_d = bus_io.row_in_flat;
                    base_d = AW'(32'(bus_io.row_count) * 32'(OUT_W));
                    col_d  = '0;
                    err_d  = 1'b0;
                    if (bus_io.row_count >= ROWS) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                en_d   = 1'b1;
                we_d   = 1'b1;
                busy_d = 1'b1;
                addr_d = base_q + AW'(col_q);
                din_d  = conv(snap_q[int'(col_q)*ACC_WIDTH +: ACC_WIDTH]);
                if (col_q == COL_LAST)
                    state_d = DONE;
                else
                    col_d = col_q + 1'b1;
            end
            DONE: begin
                en_d   = 1'b0;
                we_d   = 1'b0;
                busy_d = 1'b0;
                // stored_q low means this is the first DONE edge
                if (!stored_q) begin
                    stored_d = 1'b1;
                end else if (!bus_io.store_en) begin
                    stored_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus_io.bram_en_a   = en_q;
    assign bus_io.bram_we_a   = we_q;
    assign bus_io.bram_addr_a = addr_q;
    assign bus_io.bram_din_a  = din_q;
    assign bus_io.busy        = busy_q;
    assign bus_io.stored      = stored_q;
    assign bus_io.row_err     = err_q;
endmodule

// File: tb/tb_store_row.sv
// Directed bench for store_row with an 8x8 image and 3x3 filter (6x6 output).
// Exercises good rows, saturation, out-of-range rows, snapshotting, reset abort and a full frame.
module tb_store_row;
    typedef int arr6_t [6];
    typedef struct {
        int    rc;
        arr6_t v;
        arr6_t e;
        bit    err;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   cyc;
    int   bad_bus;
    int   hit [36];
    int   log_a [$];
    int   log_d [$];
    int   log_c [$];

    store_row_if #(
        .IMAGE_WIDTH (8),
        .IMAGE_HEIGHT(8),
        .FILTER_SIZE (3),
        .ACC_WIDTH   (16)
    ) sif ();

    store_row #(
        .IMAGE_WIDTH (8),
        .IMAGE_HEIGHT(8),
        .FILTER_SIZE (3),
        .ACC_WIDTH   (16)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus_io(sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM capture model plus bus sanity checks
    always @(posedge clk) begin
        cyc++;
        if (sif.bram_en_a && sif.bram_we_a) begin
            log_a.push_back(int'(sif.bram_addr_a));
            log_d.push_back(int'(sif.bram_din_a));
            log_c.push_back(cyc);
            if (int'(sif.bram_addr_a) < 36)
                hit[int'(sif.bram_addr_a)]++;
        end
        if ((sif.busy !== (sif.bram_en_a && sif.bram_we_a)) ||
            (sif.bram_en_a !== sif.bram_we_a))
            bad_bus++;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [95:0] pack(input arr6_t v);
        logic [95:0] p;
        p = '0;
        for (int k = 0; k < 6; k++)
            p[k*16 +: 16] = 16'(v[k]);
        return p;
    endfunction

    task automatic clear_log();
        log_a.delete();
        log_d.delete();
        log_c.delete();
    endtask

    task automatic chk_log(input string tag, input int base, input arr6_t e, input int n);
        chk($sformatf("%s_nwr", tag), log_a.size(), n);
        for (int i = 0; i < log_a.size() && i < n; i++) begin
            chk($sformatf("%s_addr%0d", tag, i), log_a[i], base + i);
            chk($sformatf("%s_data%0d", tag, i), log_d[i], e[i]);
            chk($sformatf("%s_cyc%0d", tag, i), log_c[i] - log_c[0], i);
        end
    endtask

    task automatic wait_stored(output int edges);
        edges = 0;
        do begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end while (!sif.stored && edges < 20);
    endtask

    task automatic do_row(input string tag, input int rc, input arr6_t v,
                          input arr6_t e, input bit err);
        int edges;
        clear_log();
        @(negedge clk);
        sif.store_en    = 1'b1;
        sif.row_count   = 16'(rc);
        sif.row_in_flat = pack(v);
        wait_stored(edges);
        chk($sformatf("%s_lat", tag), edges, err ? 2 : 8);
        chk($sformatf("%s_err", tag), int'(sif.row_err), int'(err));
        chk($sformatf("%s_busy", tag), int'(sif.busy), 0);
        @(negedge clk);
        chk($sformatf("%s_hold", tag), int'(sif.stored), 1);
        sif.store_en = 1'b0;
        @(negedge clk);
        chk($sformatf("%s_drop", tag), int'(sif.stored), 0);
        chk_log(tag, rc * 6, e, err ? 0 : 6);
    endtask

    vec_t  vt [3];
    arr6_t va;
    arr6_t ve;
    arr6_t vx;
    int    edges;
    int    hits_ok;

    initial begin
        checks   = 0;
        failures = 0;
        cyc      = 0;
        bad_bus  = 0;
        foreach (hit[i]) hit[i] = 0;

        vt[0].rc  = 2;
        vt[0].v   = '{0, 1, 2, 3, 4, 5};
        vt[0].e   = '{0, 1, 2, 3, 4, 5};
        vt[0].err = 1'b0;
        vt[1].rc  = 3;
        vt[1].v   = '{-5, 300, 255, 256, -32768, 128};
`ifdef STORE_ABS_EN
        vt[1].e   = '{5, 255, 255, 255, 255, 128};
`else
        vt[1].e   = '{0, 255, 255, 255, 0, 128};
`endif
        vt[1].err = 1'b0;
        vt[2].rc  = 6;
        vt[2].v   = '{9, 9, 9, 9, 9, 9};
        vt[2].e   = '{0, 0, 0, 0, 0, 0};
        vt[2].err = 1'b1;

        rst             = 1'b0;
        sif.store_en    = 1'b0;
        sif.row_count   = '0;
        sif.row_in_flat = '0;
        #2 rst = 1'b1;
        #1;
        chk("rst_en", int'(sif.bram_en_a), 0);
        chk("rst_we", int'(sif.bram_we_a), 0);
        chk("rst_addr", int'(sif.bram_addr_a), 0);
        chk("rst_din", int'(sif.bram_din_a), 0);
        chk("rst_busy", int'(sif.busy), 0);
        chk("rst_stored", int'(sif.stored), 0);
        chk("rst_err", int'(sif.row_err), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int t = 0; t < 3; t++)
            do_row($sformatf("vec%0d", t), vt[t].rc, vt[t].v, vt[t].e, vt[t].err);

        // Inputs change and store_en drops mid-row
        clear_log();
        va = '{10, 20, 30, 40, 50, 60};
        vx = '{99, 99, 99, 99, 99, 99};
        @(negedge clk);
        sif.store_en    = 1'b1;
        sif.row_count   = 16'd1;
        sif.row_in_flat = pack(va);
        repeat (2) @(negedge clk);
        sif.store_en    = 1'b0;
        sif.row_count   = 16'd4;
        sif.row_in_flat = pack(vx);
        wait_stored(edges);
        chk("snap_lat", edges + 2, 8);
        chk("snap_stored", int'(sif.stored), 1);
        @(negedge clk);
        chk("snap_pulse", int'(sif.stored), 0);
        chk_log("snap", 6, va, 6);

        // Reset lands while the third write is on the bus
        clear_log();
        va = '{7, 8, 9, 10, 11, 12};
        @(negedge clk);
        sif.store_en    = 1'b1;
        sif.row_count   = 16'd2;
        sif.row_in_flat = pack(va);
        repeat (4) @(negedge clk);
        chk("abort_we3", int'(sif.bram_we_a), 1);
        chk("abort_addr3", int'(sif.bram_addr_a), 14);
        rst = 1'b1;
        #1;
        chk("abort_en", int'(sif.bram_en_a), 0);
        chk("abort_we", int'(sif.bram_we_a), 0);
        chk("abort_addr", int'(sif.bram_addr_a), 0);
        chk("abort_din", int'(sif.bram_din_a), 0);
        chk("abort_busy", int'(sif.busy), 0);
        chk("abort_stored", int'(sif.stored), 0);
        @(negedge clk);
        rst          = 1'b0;
        sif.store_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_nwr", log_a.size(), 2);
        if (log_a.size() >= 2) begin
            chk("abort_a0", log_a[0], 12);
            chk("abort_a1", log_a[1], 13);
        end
        do_row("rerun", 2, va, va, 1'b0);

        // Full frame, rows back to back
        foreach (hit[i]) hit[i] = 0;
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < 6; k++) begin
                va[k] = r * 10 + k;
                ve[k] = r * 10 + k;
            end
            do_row($sformatf("frame%0d", r), r, va, ve, 1'b0);
        end
        hits_ok = 0;
        foreach (hit[i])
            if (hit[i] == 1) hits_ok++;
        chk("frame_cover", hits_ok, 36);
        chk("bus_consistency", bad_bus, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
